// File: rtl/fre_meas_pkg.sv
// rtl/fre_meas_pkg.sv - shared types and constants for the frequency readout controller
package fre_meas_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        CONV   = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int          DIGITS  = 9;
    localparam int          BCD_W   = 36;
    localparam logic [31:0] BCD_MAX = 32'd999_999_999;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per clock after a start pulse
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_N = DIGITS * 4;

    logic [BCD_N-1:0] bcd_q, bcd_d, adj;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // done is asserted during the final iteration, so the caller leaves on that same edge
    assign done = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
    assign busy = busy_q;
    assign bcd  = bcd_q;

    always_comb begin
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            bcd_d  = '0;
            bin_d  = din;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[BCD_N-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/fre_meas_ctrl.sv
// rtl/fre_meas_ctrl.sv - averages frequency samples, converts to BCD, commits during blanking rows
module fre_meas_ctrl
    import fre_meas_pkg::*;
#(
    parameter int          AVG_LOG2 = 4,
    parameter int          BIN_W    = 32,
    parameter logic [10:0] BLANK_Y  = 11'd20
) (
    input  logic              lcd_pclk,
    input  logic              sys_rst_n,
    input  logic              meas_valid,
    input  logic [BIN_W-1:0]  meas_data,
    output logic              meas_ready,
    input  logic [10:0]       pixel_ypos,
    output logic [BCD_W-1:0]  bcd_out,
    output logic [DIGITS-1:0] digit_mask,
    output logic              ovf,
    output logic              upd_pulse
);

    localparam int SUM_W = BIN_W + AVG_LOG2;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d, sum_nxt;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, conv_bcd;
    logic [DIGITS-1:0]   mask_q, mask_d, mask_c;
    logic                ovf_q, ovf_d;
    logic                upd_q, upd_d;
    logic                xfer, last, over, any_nz;
    logic                conv_busy, conv_done;
    logic [BIN_W-1:0]    avg, avg_sat;

    assign meas_ready = (state_q == ACCUM);
    assign xfer       = meas_valid && meas_ready;
    assign last       = (cnt_q == '1);
    assign sum_nxt    = sum_q + SUM_W'(meas_data);
    assign avg        = sum_nxt[SUM_W-1:AVG_LOG2];
    assign over       = 64'(avg) > 64'(BCD_MAX);
    assign avg_sat    = over ? BIN_W'(BCD_MAX) : avg;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (lcd_pclk),
        .rst_n  (sys_rst_n),
        .start  (xfer && last),
        .din    (avg_sat),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    // A digit is shown if it or any more significant digit is nonzero; units always shown
    always_comb begin
        mask_c = '0;
        any_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            any_nz    = any_nz | (|conv_bcd[i*4 +: 4]);
            mask_c[i] = any_nz;
        end
        mask_c[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        mask_d  = mask_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;
        case (state_q)
            ACCUM: begin
                if (xfer) begin
                    if (last) begin
                        sum_d   = '0;
                        cnt_d   = '0;
                        sat_d   = over;
                        state_d = CONV;
                    end else begin
                        sum_d = sum_nxt;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // the commit is fused with leaving WAIT so the glyph rows never see a change
                if (pixel_ypos >= BLANK_Y && !conv_busy) begin
                    bcd_d   = conv_bcd;
                    mask_d  = mask_c;
                    ovf_d   = sat_q;
                    upd_d   = 1'b1;
                    state_d = ACCUM;
                end
            end
            COMMIT:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            mask_q  <= DIGITS'(1);
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign digit_mask = mask_q;
    assign ovf        = ovf_q;
    assign upd_pulse  = upd_q;

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// tb/tb_fre_meas_ctrl.sv - vector table and scoreboard bench for fre_meas_ctrl
module tb_fre_meas_ctrl;

    typedef struct packed {
        logic [3:0][31:0] s;
        logic [10:0]      yp;
        logic [35:0]      bcd;
        logic [8:0]       mask;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [35:0] bcd;
        logic [8:0]  mask;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mv0 = 1'b0, mv1 = 1'b0;
    logic [31:0] md0 = '0, md1 = '0;
    logic [10:0] yp0 = 11'd30, yp1 = 11'd30;
    logic        mr0, mr1, ovf0, ovf1, upd0, upd1;
    logic [35:0] bcd0, bcd1;
    logic [8:0]  mask0, mask1;

    int   total = 0, bad = 0, cyc = 0, t_last0 = 0, errs;
    int   upd_cnt0 = 0, upd_cnt1 = 0;
    logic chk_lat0 = 1'b0;
    exp_t q0[$], q1[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fre_meas_ctrl #(.AVG_LOG2(2), .BIN_W(32), .BLANK_Y(11'd20)) u_dut0 (
        .lcd_pclk(clk), .sys_rst_n(rstn), .meas_valid(mv0), .meas_data(md0),
        .meas_ready(mr0), .pixel_ypos(yp0), .bcd_out(bcd0), .digit_mask(mask0),
        .ovf(ovf0), .upd_pulse(upd0)
    );

    fre_meas_ctrl #(.AVG_LOG2(1), .BIN_W(32), .BLANK_Y(11'd20)) u_dut1 (
        .lcd_pclk(clk), .sys_rst_n(rstn), .meas_valid(mv1), .meas_data(md1),
        .meas_ready(mr1), .pixel_ypos(yp1), .bcd_out(bcd1), .digit_mask(mask1),
        .ovf(ovf1), .upd_pulse(upd1)
    );

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic vec_t mkvec(input logic [31:0] a, b, c, d, input logic [10:0] yp,
                                   input logic [35:0] bcd, input logic [8:0] mask, input logic o);
        vec_t v;
        v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
        v.yp = yp; v.bcd = bcd; v.mask = mask; v.ovf = o;
        return v;
    endfunction

    function automatic exp_t mkexp(input logic [35:0] bcd, input logic [8:0] mask, input logic o);
        exp_t e;
        e.bcd = bcd; e.mask = mask; e.ovf = o;
        return e;
    endfunction

    // Scoreboards: every upd_pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rstn && upd0) begin
            upd_cnt0++;
            chk("ready_with_upd0", 36'(mr0), 36'd1);
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL upd0_unexpected: got pulse bcd=%h want none", bcd0);
            end else begin
                e = q0.pop_front();
                chk("bcd0", bcd0, e.bcd);
                chk("mask0", 36'(mask0), 36'(e.mask));
                chk("ovf0", 36'(ovf0), 36'(e.ovf));
                if (chk_lat0) begin
                    chk("latency0", 36'(cyc - t_last0), 36'd33);
                    chk_lat0 = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn && upd1) begin
            upd_cnt1++;
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL upd1_unexpected: got pulse bcd=%h want none", bcd1);
            end else begin
                e = q1.pop_front();
                chk("bcd1", bcd1, e.bcd);
                chk("mask1", 36'(mask1), 36'(e.mask));
                chk("ovf1", 36'(ovf1), 36'(e.ovf));
            end
        end
    end

    task automatic send(input int u, input logic [31:0] d);
        int n = 0;
        if (u == 0) begin mv0 = 1'b1; md0 = d; end
        else        begin mv1 = 1'b1; md1 = d; end
        while (!(u == 0 ? mr0 : mr1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL send_timeout: got no ready in %0d cycles want ready", n);
        end
        t_last0 = cyc + 1;
        @(negedge clk);
        if (u == 0) mv0 = 1'b0;
        else        mv1 = 1'b0;
    endtask

    task automatic wait_upd(input int u, input string nm);
        int start = (u == 0) ? upd_cnt0 : upd_cnt1;
        int n = 0;
        while (((u == 0) ? upd_cnt0 : upd_cnt1) == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_pulses"}, 36'(((u == 0) ? upd_cnt0 : upd_cnt1) - start), 36'd1);
        @(negedge clk);
        chk({nm, "_pulse_width"}, 36'((u == 0) ? upd0 : upd1), 36'd0);
    endtask

    initial begin
        vecs[0] = mkvec(32'd1000, 32'd1002, 32'd1004, 32'd1006, 11'd30, 36'h000001003, 9'h00F, 1'b0);
        vecs[1] = mkvec(32'd1, 32'd1, 32'd1, 32'd2, 11'd30, 36'h000000001, 9'h001, 1'b0);
        vecs[2] = mkvec(32'd1_200_000_000, 32'd1_200_000_000, 32'd1_200_000_000, 32'd1_200_000_000,
                        11'd20, 36'h999999999, 9'h1FF, 1'b1);
        vecs[3] = mkvec(32'd123456789, 32'd123456789, 32'd123456789, 32'd123456789,
                        11'd1023, 36'h123456789, 9'h1FF, 1'b0);
        vecs[4] = mkvec(32'd50, 32'd50, 32'd50, 32'd51, 11'd20, 36'h000000050, 9'h003, 1'b0);
        vecs[5] = mkvec(32'd999_999_999, 32'd999_999_999, 32'd999_999_999, 32'd999_999_999,
                        11'd25, 36'h999999999, 9'h1FF, 1'b0);
        vecs[6] = mkvec(32'd1_000_000_000, 32'd1_000_000_000, 32'd1_000_000_000, 32'd1_000_000_000,
                        11'd25, 36'h999999999, 9'h1FF, 1'b1);
        vecs[7] = mkvec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0004,
                        11'd30, 36'h999999999, 9'h1FF, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_bcd", bcd0, 36'h0);
        chk("rst_mask", 36'(mask0), 36'h001);
        chk("rst_ovf", 36'(ovf0), 36'd0);
        chk("rst_upd", 36'(upd0), 36'd0);
        chk("rst_ready", 36'(mr0), 36'd1);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            q0.push_back(mkexp(vecs[i].bcd, vecs[i].mask, vecs[i].ovf));
            yp0 = vecs[i].yp;
            chk_lat0 = (i == 0);
            for (int k = 0; k < 4; k++) send(0, vecs[i].s[k]);
            wait_upd(0, $sformatf("vec%0d", i));
        end

        // Commit held off by the text rows while the source keeps offering data
        yp0 = 11'd5;
        q0.push_back(mkexp(36'h40, 9'h003, 1'b0));
        for (int k = 0; k < 4; k++) send(0, 32'd40);
        mv0 = 1'b1;
        md0 = 32'd12345;
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (upd0 || mr0 || bcd0 !== vecs[7].bcd) errs++;
        end
        chk("hold_stable", 36'(errs), 36'd0);
        mv0 = 1'b0;
        yp0 = 11'd20;
        @(negedge clk);
        chk("hold_release_upd", 36'(upd0), 36'd1);
        @(negedge clk);
        chk("hold_release_width", 36'(upd0), 36'd0);

        yp0 = 11'd30;
        q0.push_back(mkexp(36'h8, 9'h001, 1'b0));
        for (int k = 0; k < 4; k++) send(0, 32'd8);
        wait_upd(0, "after_hold");

        // Reset in the middle of a conversion discards it
        for (int k = 0; k < 4; k++) send(0, 32'd5);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_bcd", bcd0, 36'h0);
        chk("midrst_mask", 36'(mask0), 36'h001);
        chk("midrst_upd", 36'(upd0), 36'd0);
        chk("midrst_ready", 36'(mr0), 36'd1);
        @(negedge clk);
        rstn = 1'b1;
        errs = 0;
        repeat (60) begin
            @(negedge clk);
            if (upd0) errs++;
        end
        chk("midrst_no_upd", 36'(errs), 36'd0);
        q0.push_back(mkexp(36'h0, 9'h001, 1'b0));
        for (int k = 0; k < 4; k++) send(0, 32'd0);
        wait_upd(0, "post_rst");

        // Back-to-back pairs on the two-sample instance
        q1.push_back(mkexp(36'h8, 9'h001, 1'b0));
        send(1, 32'd7);
        send(1, 32'd9);
        wait_upd(1, "pair0");
        q1.push_back(mkexp(36'h100, 9'h007, 1'b0));
        send(1, 32'd99);
        send(1, 32'd101);
        wait_upd(1, "pair1");

        chk("q0_drained", 36'(q0.size()), 36'd0);
        chk("q1_drained", 36'(q1.size()), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
